cpu_phase_sequencer: RTL and testbench

//  Multi-cycle phase controller for the single-issue CPU datapath. Replaces the free-running

---
 rtl/cpu_phase_sequencer_pkg.sv | 18 +
 rtl/cpu_phase_sequencer_mem_wait_timer.sv | 29 ++
 rtl/cpu_phase_sequencer.sv | 147 ++++++++++++++
 tb/tb_cpu_phase_sequencer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_phase_sequencer_pkg.sv
// Shared state codes and widths for the CPU phase sequencer.
package cpu_phase_sequencer_pkg;

  localparam int REGWIDTH       = 32;
  localparam int SEQ_PHASEWIDTH = 3;

  typedef enum logic [SEQ_PHASEWIDTH-1:0] {
    SEQ_IDLE     = 3'd0,
    SEQ_FETCH    = 3'd1,
    SEQ_DECODE   = 3'd2,
    SEQ_EXECUTE  = 3'd3,
    SEQ_MEM      = 3'd4,
    SEQ_MEM_WAIT = 3'd5,
    SEQ_WB       = 3'd6,
    SEQ_HALT     = 3'd7
  } state_t;

endpackage

// File: rtl/cpu_phase_sequencer_mem_wait_timer.sv
// Memory-wait watchdog counter: cleared on MEM entry, counts unanswered MEM_WAIT cycles.
module cpu_phase_sequencer_mem_wait_timer #(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  localparam logic [7:0] LAST = 8'(MEM_WAIT_MAX - 1);

  logic [7:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 8'd0;
    end else if (clear) begin
      count <= 8'd0;
    end else if (inc) begin
      count <= count + 8'd1;
    end
  end

  // Terminal count: this MEM_WAIT cycle is the last one allowed without an ack.
  assign expired = (count == LAST);

endmodule

// File: rtl/cpu_phase_sequencer.sv
// Multi-cycle CPU phase controller (Moore FSM). Optional single-step input is
// enabled by defining SEQ_SINGLE_STEP_EN.
module cpu_phase_sequencer
  import cpu_phase_sequencer_pkg::*;
#(
  parameter int RESET_HOLD   = 2,
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      run,
  input  logic                      mem_access,
  input  logic                      mem_ready,
  input  logic                      halt_req,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic                      step,
`endif
  output logic                      if_en,
  output logic                      mem_en,
  output logic                      reg_we_en,
  output logic                      pc_en,
  output logic [SEQ_PHASEWIDTH-1:0] phase,
  output logic                      busy,
  output logic                      halted,
  output logic                      timeout_err,
  output logic [REGWIDTH-1:0]       instr_count
);

  localparam logic [7:0] HOLD_INIT = 8'(RESET_HOLD);

  state_t        state;
  state_t        state_nxt;
  logic [7:0]    hold_cnt;
  logic          wait_clear;
  logic          wait_inc;
  logic          wait_expired;
  logic          step_start;

`ifdef SEQ_SINGLE_STEP_EN
  logic step_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_q <= 1'b0;
    end else begin
      step_q <= step;
    end
  end

  // Only meaningful in IDLE with run low; edges elsewhere are simply dropped.
  assign step_start = step & ~step_q & ~run;
`else
  assign step_start = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= SEQ_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt <= HOLD_INIT;
    end else if (state == SEQ_IDLE && hold_cnt != 8'd0) begin
      hold_cnt <= hold_cnt - 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeout_err <= 1'b0;
    end else if (state == SEQ_MEM_WAIT && !mem_ready && wait_expired) begin
      timeout_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_count <= '0;
    end else if (state == SEQ_WB) begin
      instr_count <= instr_count + REGWIDTH'(1);
    end
  end

  always_comb begin
    state_nxt  = state;
    wait_clear = 1'b0;
    wait_inc   = 1'b0;
    case (state)
      SEQ_IDLE: begin
        if (hold_cnt == 8'd0 && (run || step_start)) begin
          state_nxt = SEQ_FETCH;
        end
      end
      SEQ_FETCH:   state_nxt = SEQ_DECODE;
      SEQ_DECODE:  state_nxt = SEQ_EXECUTE;
      SEQ_EXECUTE: state_nxt = mem_access ? SEQ_MEM : SEQ_WB;
      SEQ_MEM: begin
        wait_clear = 1'b1;
        state_nxt  = mem_ready ? SEQ_WB : SEQ_MEM_WAIT;
      end
      SEQ_MEM_WAIT: begin
        // An ack arriving on the watchdog's last cycle still completes the access.
        if (mem_ready) begin
          state_nxt = SEQ_WB;
        end else if (wait_expired) begin
          state_nxt = SEQ_HALT;
        end else begin
          wait_inc = 1'b1;
        end
      end
      SEQ_WB: begin
        if (halt_req) begin
          state_nxt = SEQ_HALT;
        end else if (run) begin
          state_nxt = SEQ_FETCH;
        end else begin
          state_nxt = SEQ_IDLE;
        end
      end
      SEQ_HALT:    state_nxt = SEQ_HALT;
      default:     state_nxt = SEQ_IDLE;
    endcase
  end

  cpu_phase_sequencer_mem_wait_timer #(
    .MEM_WAIT_MAX (MEM_WAIT_MAX)
  ) u_mem_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (wait_clear),
    .inc     (wait_inc),
    .expired (wait_expired)
  );

  assign phase     = state;
  assign if_en     = (state == SEQ_FETCH);
  assign mem_en    = (state == SEQ_MEM) || (state == SEQ_MEM_WAIT);
  assign reg_we_en = (state == SEQ_WB);
  assign pc_en     = (state == SEQ_WB);
  assign busy      = (state != SEQ_IDLE) && (state != SEQ_HALT);
  assign halted    = (state == SEQ_HALT);

endmodule

// File: tb/tb_cpu_phase_sequencer.sv
// Directed bench for cpu_phase_sequencer: vector table plus hand-written corner sequences.
module tb_cpu_phase_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        run = 1'b0;
  logic        mem_access = 1'b0;
  logic        mem_ready = 1'b0;
  logic        halt_req = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
  logic        step = 1'b0;
`endif
  logic        if_en, mem_en, reg_we_en, pc_en, busy, halted, timeout_err;
  logic [2:0]  phase;
  logic [31:0] instr_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cpu_phase_sequencer #(
    .RESET_HOLD   (2),
    .MEM_WAIT_MAX (15)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .mem_access  (mem_access),
    .mem_ready   (mem_ready),
    .halt_req    (halt_req),
`ifdef SEQ_SINGLE_STEP_EN
    .step        (step),
`endif
    .if_en       (if_en),
    .mem_en      (mem_en),
    .reg_we_en   (reg_we_en),
    .pc_en       (pc_en),
    .phase       (phase),
    .busy        (busy),
    .halted      (halted),
    .timeout_err (timeout_err),
    .instr_count (instr_count)
  );

  // flags = {if_en, mem_en, reg_we_en, pc_en, busy, halted, timeout_err}
  typedef struct {
    logic        run;
    logic        macc;
    logic        mrdy;
    logic        hreq;
    logic [2:0]  phase;
    logic [6:0]  flags;
    logic [31:0] cnt;
  } vec_t;

  vec_t vecs[32];

  function automatic vec_t mk(logic r, logic ma, logic mr, logic hr,
                              logic [2:0] ph, logic [6:0] fl, logic [31:0] c);
    vec_t v;
    v.run = r; v.macc = ma; v.mrdy = mr; v.hreq = hr;
    v.phase = ph; v.flags = fl; v.cnt = c;
    return v;
  endfunction

  function automatic logic [6:0] flags_now();
    return {if_en, mem_en, reg_we_en, pc_en, busy, halted, timeout_err};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Async assert, release 1 time unit after an edge; hold counter restarts at 2.
  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  localparam logic [6:0] F_IDLE = 7'b0000000;
  localparam logic [6:0] F_FET  = 7'b1000100;
  localparam logic [6:0] F_BSY  = 7'b0000100;
  localparam logic [6:0] F_MEM  = 7'b0100100;
  localparam logic [6:0] F_WB   = 7'b0011100;
  localparam logic [6:0] F_HLT  = 7'b0000010;
  localparam logic [6:0] F_TO   = 7'b0000011;

  initial begin
    // Each row: inputs applied before an edge, outputs expected after it.
    vecs[0]  = mk(1,0,0,0, 3'd0, F_IDLE, 0);
    vecs[1]  = mk(1,0,0,0, 3'd0, F_IDLE, 0);
    vecs[2]  = mk(1,0,0,0, 3'd1, F_FET,  0);
    vecs[3]  = mk(1,0,0,0, 3'd2, F_BSY,  0);
    vecs[4]  = mk(1,0,0,0, 3'd3, F_BSY,  0);
    vecs[5]  = mk(1,0,0,0, 3'd6, F_WB,   0);
    vecs[6]  = mk(1,0,0,0, 3'd1, F_FET,  1);
    vecs[7]  = mk(1,0,0,0, 3'd2, F_BSY,  1);
    vecs[8]  = mk(1,0,0,0, 3'd3, F_BSY,  1);
    vecs[9]  = mk(1,0,0,0, 3'd6, F_WB,   1);
    vecs[10] = mk(1,0,0,0, 3'd1, F_FET,  2);
    vecs[11] = mk(1,0,0,0, 3'd2, F_BSY,  2);
    vecs[12] = mk(1,0,0,0, 3'd3, F_BSY,  2);
    vecs[13] = mk(1,0,0,0, 3'd6, F_WB,   2);
    vecs[14] = mk(1,0,0,0, 3'd1, F_FET,  3);
    vecs[15] = mk(1,0,0,0, 3'd2, F_BSY,  3);
    vecs[16] = mk(1,0,0,0, 3'd3, F_BSY,  3);
    vecs[17] = mk(1,1,0,0, 3'd4, F_MEM,  3);
    vecs[18] = mk(1,0,0,0, 3'd5, F_MEM,  3);
    vecs[19] = mk(1,0,0,0, 3'd5, F_MEM,  3);
    vecs[20] = mk(1,0,0,0, 3'd5, F_MEM,  3);
    vecs[21] = mk(1,0,1,0, 3'd6, F_WB,   3);
    vecs[22] = mk(1,0,0,0, 3'd1, F_FET,  4);
    vecs[23] = mk(1,0,0,0, 3'd2, F_BSY,  4);
    vecs[24] = mk(1,0,0,0, 3'd3, F_BSY,  4);
    vecs[25] = mk(1,0,0,1, 3'd6, F_WB,   4);
    vecs[26] = mk(1,0,0,0, 3'd1, F_FET,  5);
    vecs[27] = mk(1,0,0,0, 3'd2, F_BSY,  5);
    vecs[28] = mk(1,0,0,0, 3'd3, F_BSY,  5);
    vecs[29] = mk(1,0,0,0, 3'd6, F_WB,   5);
    vecs[30] = mk(0,0,0,1, 3'd7, F_HLT,  6);
    vecs[31] = mk(1,0,0,0, 3'd7, F_HLT,  6);

    // Reset state before any clock edge.
    #2 rst = 1'b1;
    #1;
    chk("reset_phase", 32'(phase), 0);
    chk("reset_flags", 32'(flags_now()), 32'(F_IDLE));
    chk("reset_count", instr_count, 0);
    tick();
    rst = 1'b0;

    for (int i = 0; i < 32; i++) begin
      run = vecs[i].run; mem_access = vecs[i].macc;
      mem_ready = vecs[i].mrdy; halt_req = vecs[i].hreq;
      tick();
      chk($sformatf("vec%0d_phase", i), 32'(phase), 32'(vecs[i].phase));
      chk($sformatf("vec%0d_flags", i), 32'(flags_now()), 32'(vecs[i].flags));
      chk($sformatf("vec%0d_count", i), instr_count, vecs[i].cnt);
    end

    // run dropped in DECODE: instruction completes, then IDLE; run back -> FETCH.
    run = 1'b0; halt_req = 1'b0; mem_access = 1'b0; mem_ready = 1'b0;
    do_reset();
    run = 1'b1;
    repeat (4) tick();
    chk("rundrop_decode", 32'(phase), 2);
    run = 1'b0;
    tick();
    tick();
    chk("rundrop_wb", 32'(phase), 6);
    tick();
    chk("rundrop_idle", 32'(phase), 0);
    chk("rundrop_busy", 32'(busy), 0);
    chk("rundrop_count", instr_count, 1);
    tick();
    chk("rundrop_stays_idle", 32'(phase), 0);
    run = 1'b1;
    tick();
    chk("rerun_fetch", 32'(phase), 1);

    // Watchdog: no ack ever -> 15 MEM_WAIT cycles, then HALT with timeout_err.
    tick();
    mem_access = 1'b1;
    tick();
    chk("wd_exec", 32'(phase), 3);
    tick();
    mem_access = 1'b0;
    chk("wd_mem", 32'(phase), 4);
    for (int k = 0; k < 15; k++) begin
      tick();
      chk($sformatf("wd_wait%0d", k), 32'(phase), 5);
      chk($sformatf("wd_to%0d", k), 32'(timeout_err), 0);
    end
    tick();
    chk("wd_halt_flags", 32'(flags_now()), 32'(F_TO));
    chk("wd_halt_phase", 32'(phase), 7);
    repeat (5) tick();
    chk("wd_halt_sticky", 32'(phase), 7);
    chk("wd_count_frozen", instr_count, 1);

    // Async reset mid MEM_WAIT with five instructions retired.
    do_reset();
    repeat (23) tick();
    chk("ar_fetch", 32'(phase), 1);
    chk("ar_count5", instr_count, 5);
    tick();
    mem_access = 1'b1;
    tick();
    tick();
    mem_access = 1'b0;
    tick();
    chk("ar_in_wait", 32'(phase), 5);
    #3 rst = 1'b1;
    #1;
    chk("ar_phase", 32'(phase), 0);
    chk("ar_flags", 32'(flags_now()), 32'(F_IDLE));
    chk("ar_count", instr_count, 0);
    tick();
    rst = 1'b0;
    tick();
    tick();
    chk("ar_hold", 32'(phase), 0);
    tick();
    chk("ar_restart", 32'(phase), 1);

`ifdef SEQ_SINGLE_STEP_EN
    run = 1'b0;
    do_reset();
    tick();
    tick();
    for (int p = 0; p < 3; p++) begin
      step = 1'b1;
      tick();
      chk($sformatf("step%0d_fetch", p), 32'(phase), 1);
      step = 1'b0;
      repeat (4) tick();
      chk($sformatf("step%0d_idle", p), 32'(phase), 0);
    end
    chk("step_count", instr_count, 3);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
